// File: rtl/stack_game_core.sv
// Playfield engine for the falling-brick game: NCOLS piles, one falling brick,
// gravity, left/right moves, line clear, game-over detection and a saturating score.
module stack_game_core #(
    parameter int NCOLS   = 3,
    parameter int DEPTH   = 7,
    parameter int HW      = 3,
    parameter int CW      = 2,
    parameter int SCORE_W = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  drop_tick,
    input  logic                  btn_plus,
    input  logic                  btn_moins,
    output logic [NCOLS*HW-1:0]   heights,
    output logic [CW-1:0]         brick_col,
    output logic [HW-1:0]         brick_row,
    output logic                  aligne,
    output logic                  perdu,
    output logic [SCORE_W-1:0]    score
);

    typedef enum logic [1:0] {FALL, CHECK, SPAWN, LOST} state_t;

    localparam logic [CW-1:0] MID_COL = CW'(NCOLS / 2);
    localparam logic [HW-1:0] TOP_ROW = HW'(DEPTH - 1);
    localparam logic [HW-1:0] FULL_H  = HW'(DEPTH);

    state_t               state, state_n;
    logic [HW-1:0]        h [NCOLS];
    logic [HW-1:0]        h_n [NCOLS];
    logic [CW-1:0]        col_n;
    logic [HW-1:0]        row_n;
    logic                 aligne_n, perdu_n;
    logic [SCORE_W-1:0]   score_n;

    logic [HW-1:0]        cur_h, right_h, left_h;
    logic                 all_nonzero, can_right, can_left;

    // Heights of the brick's column and its two neighbours, plus the line-clear condition.
    always_comb begin
        cur_h       = '0;
        right_h     = '0;
        left_h      = '0;
        all_nonzero = 1'b1;
        for (int c = 0; c < NCOLS; c++) begin
            if (CW'(c) == brick_col)             cur_h   = h[c];
            if (CW'(c) == brick_col + CW'(1))    right_h = h[c];
            if (CW'(c) + CW'(1) == brick_col)    left_h  = h[c];
            if (h[c] == '0)                      all_nonzero = 1'b0;
        end
    end

    assign can_right = (int'(brick_col) < NCOLS - 1) && (right_h <= brick_row);
    assign can_left  = (brick_col != '0) && (left_h <= brick_row);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_n  = state;
        h_n      = h;
        col_n    = brick_col;
        row_n    = brick_row;
        aligne_n = aligne;
        perdu_n  = perdu;
        score_n  = score;
        if (enable) begin
            unique case (state)
                FALL: begin
                    if (drop_tick) begin
                        if (brick_row == cur_h) begin
                            for (int c = 0; c < NCOLS; c++)
                                if (CW'(c) == brick_col) h_n[c] = h[c] + HW'(1);
                            state_n = CHECK;
                        end else begin
                            row_n = brick_row - HW'(1);
                        end
                    end else if (btn_plus && !btn_moins) begin
                        if (can_right) col_n = brick_col + CW'(1);
                    end else if (btn_moins && !btn_plus) begin
                        if (can_left) col_n = brick_col - CW'(1);
                    end
                end
                CHECK: begin
                    if (all_nonzero) begin
                        for (int c = 0; c < NCOLS; c++) h_n[c] = h[c] - HW'(1);
                        if (score != '1) score_n = score + SCORE_W'(1);
                        aligne_n = 1'b1;
                    end
                    state_n = SPAWN;
                end
                SPAWN: begin
                    aligne_n = 1'b0;
                    if (h[NCOLS/2] == FULL_H) begin
                        perdu_n = 1'b1;
                        state_n = LOST;
                    end else begin
                        col_n   = MID_COL;
                        row_n   = TOP_ROW;
                        state_n = FALL;
                    end
                end
                LOST: ;
                default: state_n = FALL;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FALL;
            brick_col <= MID_COL;
            brick_row <= TOP_ROW;
            aligne    <= 1'b0;
            perdu     <= 1'b0;
            score     <= '0;
            // NOTE: the pile array is a handful of flops, not a RAM, so it is cleared on reset.
            for (int c = 0; c < NCOLS; c++) h[c] <= '0;
        end else begin
            state     <= state_n;
            brick_col <= col_n;
            brick_row <= row_n;
            aligne    <= aligne_n;
            perdu     <= perdu_n;
            score     <= score_n;
            h         <= h_n;
        end
    end

    always_comb begin
        heights = '0;
        for (int c = 0; c < NCOLS; c++) heights[c*HW +: HW] = h[c];
    end

endmodule

// File: tb/tb_stack_game_core.sv
// Directed bench for stack_game_core (NCOLS=3, DEPTH=7): a vector table for
// moves/gravity/landing, then hand-written sequences for clear, blocking, game over and freeze.
module tb_stack_game_core;

    localparam int NCOLS   = 3;
    localparam int DEPTH   = 7;
    localparam int HW      = 3;
    localparam int CW      = 2;
    localparam int SCORE_W = 14;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                drop_tick;
    logic                btn_plus;
    logic                btn_moins;
    logic [NCOLS*HW-1:0] heights;
    logic [CW-1:0]       brick_col;
    logic [HW-1:0]       brick_row;
    logic                aligne;
    logic                perdu;
    logic [SCORE_W-1:0]  score;

    int n_checks = 0;
    int n_pass   = 0;

    typedef logic [29:0] snap_t;

    typedef struct {
        logic t;
        logic p;
        logic m;
        int   col;
        int   row;
        int   h1;
    } vec_t;

    vec_t vecs [18];

    stack_game_core #(
        .NCOLS(NCOLS), .DEPTH(DEPTH), .HW(HW), .CW(CW), .SCORE_W(SCORE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .drop_tick (drop_tick),
        .btn_plus  (btn_plus),
        .btn_moins (btn_moins),
        .heights   (heights),
        .brick_col (brick_col),
        .brick_row (brick_row),
        .aligne    (aligne),
        .perdu     (perdu),
        .score     (score)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(input bit p, input bit a, input int sc,
                                 input int h0, input int h1, input int h2,
                                 input int col, input int row);
        return {p, a, 14'(sc), 3'(h2), 3'(h1), 3'(h0), 2'(col), 3'(row)};
    endfunction

    function automatic string show(input snap_t s);
        return $sformatf("perdu=%0d aligne=%0d score=%0d h=%0d/%0d/%0d col=%0d row=%0d",
                         s[29], s[28], s[27:14], s[7:5], s[10:8], s[13:11], s[4:3], s[2:0]);
    endfunction

    task automatic check(input string name, input snap_t exp);
        snap_t act;
        act = {perdu, aligne, score, heights, brick_col, brick_row};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, show(act), show(exp));
    endtask

    task automatic step(input logic t, input logic p, input logic m);
        drop_tick = t;
        btn_plus  = p;
        btn_moins = m;
        @(posedge clk);
        #1;
        drop_tick = 1'b0;
        btn_plus  = 1'b0;
        btn_moins = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        drop_tick = 1'b0;
        btn_plus  = 1'b0;
        btn_moins = 1'b0;

        // {tick, plus, moins, col, row, height[1]} after each cycle, starting at col 1 row 6
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 2, 6, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2, 6, 0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 2, 6, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 2, 6, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1, 6, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 0, 6, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 0, 6, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1, 6, 0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1, 5, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1, 4, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1, 3, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1, 2, 0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1, 1, 0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1, 0, 0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1, 0, 1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1, 0, 1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1, 6, 1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1, 6, 1};

        #12;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t1_reset", mk(0, 0, 0, 0, 0, 0, 1, 6));

        // moves, edges, gravity priority, landing, inputs dropped in CHECK/SPAWN
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].t, vecs[i].p, vecs[i].m);
            check($sformatf("vec%0d", i), mk(0, 0, 0, 0, vecs[i].h1, 0, vecs[i].col, vecs[i].row));
        end

        // line clear: build {1,0,1}, then land the centre brick
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        ticks(7);
        idle(2);
        step(1'b0, 1'b0, 1'b1);
        ticks(7);
        idle(2);
        check("t4_setup", mk(0, 0, 0, 1, 0, 1, 1, 6));
        ticks(7);
        check("t4_land", mk(0, 0, 0, 1, 1, 1, 1, 0));
        idle(1);
        check("t4_clear", mk(0, 1, 1, 0, 0, 0, 1, 0));
        idle(1);
        check("t4_spawn", mk(0, 0, 1, 0, 0, 0, 1, 6));

        // move blocked by a taller neighbour, then allowed one row higher
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1);
            ticks(7 - k);
            idle(2);
        end
        check("t5_setup", mk(0, 0, 1, 3, 0, 0, 1, 6));
        ticks(4);
        step(1'b0, 1'b0, 1'b1);
        check("t5_blocked", mk(0, 0, 1, 3, 0, 0, 1, 2));
        ticks(3);
        idle(2);
        ticks(3);
        step(1'b0, 1'b0, 1'b1);
        check("t5b_move", mk(0, 0, 1, 3, 1, 0, 0, 3));

        // asynchronous reset mid-game
        reset = 1'b0;
        #2;
        check("t6_async_reset", mk(0, 0, 0, 0, 0, 0, 1, 6));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // stack the centre column to DEPTH -> game over
        for (int k = 0; k < 7; k++) begin
            ticks(7 - k);
            if (k < 6) idle(2);
        end
        check("t6_land7", mk(0, 0, 0, 0, 7, 0, 1, 6));
        idle(2);
        check("t6_perdu", mk(1, 0, 0, 0, 7, 0, 1, 6));
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("t6_lost_hold", mk(1, 0, 0, 0, 7, 0, 1, 6));
        do_reset();
        check("t6_reset_recover", mk(0, 0, 0, 0, 0, 0, 1, 6));

        // freeze: ticks and buttons with enable low are lost
        enable = 1'b0;
        ticks(3);
        step(1'b0, 1'b1, 1'b0);
        check("t7_frozen", mk(0, 0, 0, 0, 0, 0, 1, 6));
        enable = 1'b1;
        ticks(1);
        check("t7_resume", mk(0, 0, 0, 0, 0, 0, 1, 5));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
